control_sequencer: RTL and testbench

//  Microcode sequencer driving every bus enable/load strobe of the 8-bit bus CPU, including the
//  ALU's alu_enable/rega_*/regb_*/sub_enable. Sits upstream of the ALU and consumes its carry_out.

---
 rtl/control_sequencer_pkg.sv | 43 ++++
 rtl/control_sequencer_if.sv | 36 +++
 rtl/control_sequencer_flag_reg.sv | 28 ++
 rtl/control_sequencer.sv | 136 +++++++++++++
 tb/tb_control_sequencer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared opcode/microstep encodings and the strobe bundle for the 8-bit bus CPU sequencer.
package control_sequencer_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_e;

  typedef struct packed {
    logic pc_out_en;
    logic pc_inc;
    logic pc_load;
    logic mar_load;
    logic ram_out_en;
    logic ram_write;
    logic ir_load;
    logic ir_out_en;
    logic rega_enable;
    logic rega_write_enable;
    logic regb_write_enable;
    logic alu_enable;
    logic sub_enable;
    logic out_load;
  } strobes_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath connection: instruction/status inputs and every bus strobe.
interface control_sequencer_if
  import control_sequencer_pkg::*;
#(
  parameter int WIDTH = DATA_W
) ();

  logic             step_en;
  logic [3:0]       opcode;
  logic             carry_in;
  logic [WIDTH-1:0] bus_in;

  logic pc_out_en, pc_inc, pc_load;
  logic mar_load, ram_out_en, ram_write;
  logic ir_load, ir_out_en;
  logic rega_enable, rega_write_enable, regb_write_enable, alu_enable, sub_enable;
  logic out_load;

  logic [2:0] step;
  logic       flag_c, flag_z, halted;

  modport master (
    input  step_en, opcode, carry_in, bus_in,
    output pc_out_en, pc_inc, pc_load, mar_load, ram_out_en, ram_write,
           ir_load, ir_out_en, rega_enable, rega_write_enable, regb_write_enable,
           alu_enable, sub_enable, out_load, step, flag_c, flag_z, halted
  );

  modport slave (
    output step_en, opcode, carry_in, bus_in,
    input  pc_out_en, pc_inc, pc_load, mar_load, ram_out_en, ram_write,
           ir_load, ir_out_en, rega_enable, rega_write_enable, regb_write_enable,
           alu_enable, sub_enable, out_load, step, flag_c, flag_z, halted
  );

endinterface

// File: rtl/control_sequencer_flag_reg.sv
// Carry/zero flag storage: loads on i_load, cleared by synchronous reset.
module control_sequencer_flag_reg (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_c,
  input  logic i_z,
  output logic o_c,
  output logic o_z
);

  logic r_c, r_z;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
    end else if (i_load) begin
      r_c <= i_c;
      r_z <= i_z;
    end
  end

  assign o_c = r_c;
  assign o_z = r_z;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: fetch T0-T1, opcode-specific execute T2-T5, sticky HALT, ALU flag latch.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input logic               clk,
  input logic               rst,
  control_sequencer_if.master bus
);

  step_e    r_step;
  logic     r_halted;
  strobes_t w_dec, w_strb;
  logic     w_run, w_flag_load, w_flag_c, w_flag_z;

  assign w_run       = bus.step_en && !r_halted;
  assign w_flag_load = w_run && (r_step == T5) && is_alu_op(bus.opcode);

  control_sequencer_flag_reg u_flag_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_flag_load),
    .i_c    (bus.carry_in),
    .i_z    (bus.bus_in == '0),
    .o_c    (w_flag_c),
    .o_z    (w_flag_z)
  );

  // HLT parks at T2 with r_halted set; only rst leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else begin
      case (r_step)
        T0: if (w_run) r_step <= T1;
        T1: if (w_run) r_step <= T2;
        T2: if (w_run) begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: r_step   <= T3;
            OP_HLT:                         r_halted <= 1'b1;
            default:                        r_step   <= T0;
          endcase
        end
        T3: if (w_run) r_step <= is_alu_op(bus.opcode) ? T4 : T0;
        T4: if (w_run) r_step <= T5;
        T5: if (w_run) r_step <= T0;
        default: r_step <= T0;
      endcase
    end
  end

  always_comb begin
    // NOTE: the all-zero default keeps this decode free of inferred latches.
    w_dec = '0;
    case (r_step)
      T0: begin
        w_dec.pc_out_en = 1'b1;
        w_dec.mar_load  = 1'b1;
      end
      T1: begin
        w_dec.ram_out_en = 1'b1;
        w_dec.ir_load    = 1'b1;
        w_dec.pc_inc     = 1'b1;
      end
      T2: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            w_dec.ir_out_en = 1'b1;
            w_dec.mar_load  = 1'b1;
          end
          OP_LDI: begin
            w_dec.ir_out_en         = 1'b1;
            w_dec.rega_write_enable = 1'b1;
          end
          OP_JMP, OP_JC, OP_JZ: begin
            w_dec.ir_out_en = (bus.opcode == OP_JMP) ||
                              (bus.opcode == OP_JC && w_flag_c) ||
                              (bus.opcode == OP_JZ && w_flag_z);
            w_dec.pc_load   = w_dec.ir_out_en;
          end
          OP_OUT: begin
            w_dec.rega_enable = 1'b1;
            w_dec.out_load    = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (bus.opcode)
          OP_LDA: begin
            w_dec.ram_out_en        = 1'b1;
            w_dec.rega_write_enable = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_dec.ram_out_en        = 1'b1;
            w_dec.regb_write_enable = 1'b1;
          end
          OP_STA: begin
            w_dec.rega_enable = 1'b1;
            w_dec.ram_write   = 1'b1;
          end
          default: ;
        endcase
      end
      // T4 only lets the ALU result register settle after reg_b loads.
      T4: w_dec.sub_enable = (bus.opcode == OP_SUB);
      T5: begin
        w_dec.alu_enable        = is_alu_op(bus.opcode);
        w_dec.rega_write_enable = is_alu_op(bus.opcode);
        w_dec.sub_enable        = (bus.opcode == OP_SUB);
      end
      default: ;
    endcase
    w_strb = (rst || !w_run) ? '0 : w_dec;
  end

  assign bus.pc_out_en         = w_strb.pc_out_en;
  assign bus.pc_inc            = w_strb.pc_inc;
  assign bus.pc_load           = w_strb.pc_load;
  assign bus.mar_load          = w_strb.mar_load;
  assign bus.ram_out_en        = w_strb.ram_out_en;
  assign bus.ram_write         = w_strb.ram_write;
  assign bus.ir_load           = w_strb.ir_load;
  assign bus.ir_out_en         = w_strb.ir_out_en;
  assign bus.rega_enable       = w_strb.rega_enable;
  assign bus.rega_write_enable = w_strb.rega_write_enable;
  assign bus.regb_write_enable = w_strb.regb_write_enable;
  assign bus.alu_enable        = w_strb.alu_enable;
  assign bus.sub_enable        = w_strb.sub_enable;
  assign bus.out_load          = w_strb.out_load;
  assign bus.step              = r_step;
  assign bus.flag_c            = w_flag_c;
  assign bus.flag_z            = w_flag_z;
  assign bus.halted            = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Vector-table bench for control_sequencer: per-cycle inputs with expected strobes/state, scoreboarded.
module tb_control_sequencer;

  localparam logic [13:0] PC_OUT  = 14'h2000, PC_INC = 14'h1000, PC_LOAD = 14'h0800;
  localparam logic [13:0] MAR     = 14'h0400, RAM_OUT = 14'h0200, RAM_WR = 14'h0100;
  localparam logic [13:0] IR_LOAD = 14'h0080, IR_OUT = 14'h0040, A_EN = 14'h0020;
  localparam logic [13:0] A_WE    = 14'h0010, B_WE = 14'h0008, ALU = 14'h0004;
  localparam logic [13:0] SUB     = 14'h0002, OUTL = 14'h0001, NONE = 14'h0000;
  localparam logic [13:0] F0 = PC_OUT | MAR;
  localparam logic [13:0] F1 = RAM_OUT | IR_LOAD | PC_INC;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic        cin;
    logic [7:0]  bus;
    logic [13:0] strb;
    logic [2:0]  step;
    logic        c;
    logic        z;
    logic        h;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  control_sequencer_if #(.WIDTH(8)) bus ();

  control_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  vec_t            vq[$];
  logic [19:0]     sb[$];
  int              n_vec  = 0;
  int              n_miss = 0;

  function automatic logic [13:0] act_strb();
    return {bus.pc_out_en, bus.pc_inc, bus.pc_load, bus.mar_load, bus.ram_out_en,
            bus.ram_write, bus.ir_load, bus.ir_out_en, bus.rega_enable,
            bus.rega_write_enable, bus.regb_write_enable, bus.alu_enable,
            bus.sub_enable, bus.out_load};
  endfunction

  task automatic add(input logic r, input logic en, input logic [3:0] op,
                     input logic cin, input logic [7:0] b, input logic [13:0] s,
                     input logic [2:0] st, input logic c, input logic z, input logic h);
    vec_t v;
    v = '{rst: r, en: en, op: op, cin: cin, bus: b, strb: s, step: st, c: c, z: z, h: h};
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    logic [19:0] exp_v, act_v;
    @(posedge clk);
    #1;
    rst          = v.rst;
    bus.step_en  = v.en;
    bus.opcode   = v.op;
    bus.carry_in = v.cin;
    bus.bus_in   = v.bus;
    sb.push_back({v.strb, v.step, v.c, v.z, v.h});
    @(negedge clk);
    act_v = {act_strb(), bus.step, bus.flag_c, bus.flag_z, bus.halted};
    exp_v = sb.pop_front();
    n_vec++;
    if (act_v !== exp_v) begin
      n_miss++;
      $display("FAIL vec%0d: got strb=%h step=%0d c=%b z=%b h=%b, want strb=%h step=%0d c=%b z=%b h=%b",
               n_vec, act_v[19:6], act_v[5:3], act_v[2], act_v[1], act_v[0],
               exp_v[19:6], exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.step_en  = 1'b0;
    bus.opcode   = 4'h0;
    bus.carry_in = 1'b0;
    bus.bus_in   = 8'h00;
    repeat (2) @(posedge clk);

    // LDA: reset state, fetch, two execute steps, back to T0
    add(1, 1, 4'h1, 0, 8'h00, NONE,          3'd0, 0, 0, 0);
    add(0, 1, 4'h1, 0, 8'h00, F0,            3'd0, 0, 0, 0);
    add(0, 1, 4'h1, 0, 8'h00, F1,            3'd1, 0, 0, 0);
    add(0, 1, 4'h1, 0, 8'h00, IR_OUT | MAR,  3'd2, 0, 0, 0);
    add(0, 1, 4'h1, 0, 8'h00, RAM_OUT | A_WE, 3'd3, 0, 0, 0);
    // SUB with carry=1, bus=0 -> C=1 Z=1
    add(0, 1, 4'h3, 0, 8'h00, F0,            3'd0, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, F1,            3'd1, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, IR_OUT | MAR,  3'd2, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, RAM_OUT | B_WE, 3'd3, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, SUB,           3'd4, 0, 0, 0);
    add(0, 1, 4'h3, 1, 8'h00, ALU | A_WE | SUB, 3'd5, 0, 0, 0);
    // ADD with carry=0, bus=5 -> C=0 Z=0
    add(0, 1, 4'h2, 0, 8'h00, F0,            3'd0, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h00, F1,            3'd1, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h00, IR_OUT | MAR,  3'd2, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h00, RAM_OUT | B_WE, 3'd3, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h00, NONE,          3'd4, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h05, ALU | A_WE,    3'd5, 1, 1, 0);
    // JC not taken
    add(0, 1, 4'h7, 0, 8'h00, F0,            3'd0, 0, 0, 0);
    add(0, 1, 4'h7, 0, 8'h00, F1,            3'd1, 0, 0, 0);
    add(0, 1, 4'h7, 0, 8'h00, NONE,          3'd2, 0, 0, 0);
    // SUB with carry=1, bus=5 -> C=1 Z=0
    add(0, 1, 4'h3, 0, 8'h00, F0,            3'd0, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, F1,            3'd1, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, IR_OUT | MAR,  3'd2, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, RAM_OUT | B_WE, 3'd3, 0, 0, 0);
    add(0, 1, 4'h3, 0, 8'h00, SUB,           3'd4, 0, 0, 0);
    add(0, 1, 4'h3, 1, 8'h05, ALU | A_WE | SUB, 3'd5, 0, 0, 0);
    // JC taken, JZ not taken, JMP, LDI, STA, OUT, NOP, op 9 as NOP
    add(0, 1, 4'h7, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h7, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h7, 0, 8'h00, IR_OUT | PC_LOAD, 3'd2, 1, 0, 0);
    add(0, 1, 4'h8, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h8, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h8, 0, 8'h00, NONE,          3'd2, 1, 0, 0);
    add(0, 1, 4'h6, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h6, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h6, 0, 8'h00, IR_OUT | PC_LOAD, 3'd2, 1, 0, 0);
    add(0, 1, 4'h5, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h5, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h5, 0, 8'h00, IR_OUT | A_WE, 3'd2, 1, 0, 0);
    add(0, 1, 4'h4, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h4, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h4, 0, 8'h00, IR_OUT | MAR,  3'd2, 1, 0, 0);
    add(0, 1, 4'h4, 0, 8'h00, A_EN | RAM_WR, 3'd3, 1, 0, 0);
    add(0, 1, 4'hE, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'hE, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'hE, 0, 8'h00, A_EN | OUTL,   3'd2, 1, 0, 0);
    add(0, 1, 4'h0, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h0, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h0, 0, 8'h00, NONE,          3'd2, 1, 0, 0);
    add(0, 1, 4'h9, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h9, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h9, 0, 8'h00, NONE,          3'd2, 1, 0, 0);

    foreach (vq[i]) apply(vq[i]);
    vq.delete();

    // ADD paused at T3 for 3 clks and at T5 (flags must not latch while paused)
    add(0, 1, 4'h2, 0, 8'h00, F0,            3'd0, 1, 0, 0);
    add(0, 1, 4'h2, 0, 8'h00, F1,            3'd1, 1, 0, 0);
    add(0, 1, 4'h2, 0, 8'h00, IR_OUT | MAR,  3'd2, 1, 0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 0, 4'h2, 0, 8'h00, NONE,        3'd3, 1, 0, 0);
    add(0, 1, 4'h2, 0, 8'h00, RAM_OUT | B_WE, 3'd3, 1, 0, 0);
    add(0, 1, 4'h2, 0, 8'h00, NONE,          3'd4, 1, 0, 0);
    add(0, 0, 4'h2, 0, 8'h05, NONE,          3'd5, 1, 0, 0);
    add(0, 1, 4'h2, 1, 8'h00, ALU | A_WE,    3'd5, 1, 0, 0);
    // rst during T4 of ADD with flags set
    add(0, 1, 4'h2, 0, 8'h00, F0,            3'd0, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h00, F1,            3'd1, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h00, IR_OUT | MAR,  3'd2, 1, 1, 0);
    add(0, 1, 4'h2, 0, 8'h00, RAM_OUT | B_WE, 3'd3, 1, 1, 0);
    add(1, 1, 4'h2, 0, 8'h00, NONE,          3'd4, 1, 1, 0);
    // HLT: halted after the T2 edge, frozen regardless of step_en, cleared only by rst
    add(0, 1, 4'hF, 0, 8'h00, F0,            3'd0, 0, 0, 0);
    add(0, 1, 4'hF, 0, 8'h00, F1,            3'd1, 0, 0, 0);
    add(0, 1, 4'hF, 0, 8'h00, NONE,          3'd2, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      add(0, 1'($urandom_range(0, 1)), 4'hF, 1'($urandom_range(0, 1)), 8'($urandom),
          NONE, 3'd2, 0, 0, 1);
    add(1, 1, 4'hF, 0, 8'h00, NONE,          3'd2, 0, 0, 1);
    add(0, 1, 4'h1, 0, 8'h00, F0,            3'd0, 0, 0, 0);
    add(0, 1, 4'h1, 0, 8'h00, F1,            3'd1, 0, 0, 0);

    foreach (vq[i]) apply(vq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
